// File: rtl/banco_fifos.sv
// rtl/banco_fifos.sv - bank of independent circular-buffer queues with a shared arbitrated pop port
// Each queue accepts pushes independently; one queue per cycle is popped into a registered output.
module banco_fifos #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int BUF_WIDTH      = 3,
  localparam int SEL_W         = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [QUEUE_QUANTITY-1:0]           push,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in,
  input  logic [SEL_W-1:0]                    selector,
  input  logic                                selector_enb,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                valid_out,
  output logic [QUEUE_QUANTITY-1:0]           buf_empty,
  output logic [QUEUE_QUANTITY-1:0]           buf_full,
  output logic [QUEUE_QUANTITY-1:0]           push_err,
  output logic                                pop_err
);

  localparam int DEPTH = 1 << BUF_WIDTH;
  localparam int CW    = BUF_WIDTH + 1;

  logic [DATA_BITS-1:0] mem [QUEUE_QUANTITY][DEPTH];

  logic [BUF_WIDTH-1:0] wr_ptr_q [QUEUE_QUANTITY];
  logic [BUF_WIDTH-1:0] wr_ptr_d [QUEUE_QUANTITY];
  logic [BUF_WIDTH-1:0] rd_ptr_q [QUEUE_QUANTITY];
  logic [BUF_WIDTH-1:0] rd_ptr_d [QUEUE_QUANTITY];
  logic [CW-1:0]        count_q  [QUEUE_QUANTITY];
  logic [CW-1:0]        count_d  [QUEUE_QUANTITY];

  logic [DATA_BITS-1:0]      data_out_q, data_out_d;
  logic                      valid_out_q, valid_out_d;
  logic [QUEUE_QUANTITY-1:0] push_err_q, push_err_d;
  logic                      pop_err_q, pop_err_d;

  logic [QUEUE_QUANTITY-1:0] push_ok;
  logic [QUEUE_QUANTITY-1:0] pop_hit;
  logic                      sel_nonempty;
  logic                      pop_ok;

  // Flags come only from registered counts so the arbiter never sees an input-to-flag path.
  always_comb begin
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      buf_empty[i] = (count_q[i] == '0);
      buf_full[i]  = (count_q[i] == CW'(DEPTH));
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    push_ok      = '0;
    pop_hit      = '0;
    push_err_d   = '0;
    sel_nonempty = 1'b0;

    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (selector == SEL_W'(i) && !buf_empty[i]) begin
        sel_nonempty = 1'b1;
      end
    end
    pop_ok      = enb && selector_enb && sel_nonempty;
    valid_out_d = pop_ok;
    pop_err_d   = enb && selector_enb && !sel_nonempty;

    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      push_ok[i]    = enb && push[i] && !buf_full[i];
      push_err_d[i] = enb && push[i] && buf_full[i];
      pop_hit[i]    = pop_ok && (selector == SEL_W'(i));
      if (push_ok[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + BUF_WIDTH'(1);
      end
      if (pop_hit[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + BUF_WIDTH'(1);
        data_out_d  = mem[i][rd_ptr_q[i]];
      end
      case ({push_ok[i], pop_hit[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      push_err_q  <= '0;
      pop_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      push_err_q  <= push_err_d;
      pop_err_q   <= pop_err_d;
    end
  end

  // Storage is left unreset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (!rst && push_ok[i]) begin
        mem[i][wr_ptr_q[i]] <= data_in[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign push_err  = push_err_q;
  assign pop_err   = pop_err_q;

endmodule

// File: tb/tb_banco_fifos.sv
// tb/tb_banco_fifos.sv - directed self-checking bench for banco_fifos
module tb_banco_fifos;

  logic        clk;
  logic        rst;
  logic        enb;
  logic [3:0]  push;
  logic [31:0] data_in;
  logic [1:0]  selector;
  logic        selector_enb;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [3:0]  buf_empty;
  logic [3:0]  buf_full;
  logic [3:0]  push_err;
  logic        pop_err;

  int total;
  int bad;

  banco_fifos dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .push         (push),
    .data_in      (data_in),
    .selector     (selector),
    .selector_enb (selector_enb),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .push_err     (push_err),
    .pop_err      (pop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push         = 4'b0000;
    selector_enb = 1'b0;
  endtask

  task automatic push_one(input int q, input logic [7:0] d);
    push              = 4'b0001 << q;
    data_in[q*8 +: 8] = d;
    selector_enb      = 1'b0;
    step();
    push = 4'b0000;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    enb          = 1'b1;
    push         = 4'b1111;
    data_in      = 32'hDEADBEEF;
    selector     = 2'd0;
    selector_enb = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (buf_empty !== 4'b1111) begin
        bad++; $display("FAIL reset_empty cyc=%0d got=%b want=1111", c, buf_empty);
      end
      total++;
      if (buf_full !== 4'b0000 || valid_out !== 1'b0) begin
        bad++; $display("FAIL reset_full_valid cyc=%0d got full=%b valid=%b want 0000/0", c, buf_full, valid_out);
      end
      total++;
      if (data_out !== 8'h00 || push_err !== 4'b0000 || pop_err !== 1'b0) begin
        bad++; $display("FAIL reset_out cyc=%0d got data=%h perr=%b poperr=%b want 00/0000/0", c, data_out, push_err, pop_err);
      end
    end
    rst = 1'b0;
    idle();
    step();
  endtask

  task automatic test_fifo_order();
    logic [7:0] exp_words [3];
    exp_words = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 3; k++) push_one(2, exp_words[k]);
    total++;
    if (buf_empty !== 4'b1011) begin
      bad++; $display("FAIL order_empty got=%b want=1011", buf_empty);
    end
    selector     = 2'd2;
    selector_enb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (valid_out !== 1'b1 || data_out !== exp_words[k]) begin
        bad++; $display("FAIL order_pop%0d got valid=%b data=%h want 1/%h", k, valid_out, data_out, exp_words[k]);
      end
    end
    idle();
    step();
    total++;
    if (valid_out !== 1'b0 || data_out !== 8'h33 || buf_empty[2] !== 1'b1) begin
      bad++; $display("FAIL order_after got valid=%b data=%h empty2=%b want 0/33/1", valid_out, data_out, buf_empty[2]);
    end
  endtask

  task automatic test_full_wrap();
    for (int k = 0; k < 8; k++) begin
      push_one(0, 8'(8'h40 + k));
      total++;
      if (buf_full[0] !== (k == 7)) begin
        bad++; $display("FAIL wrap_full k=%0d got=%b want=%b", k, buf_full[0], (k == 7));
      end
    end
    push_one(0, 8'hEE);
    total++;
    if (push_err !== 4'b0001) begin
      bad++; $display("FAIL wrap_push_err got=%b want=0001", push_err);
    end
    step();
    total++;
    if (push_err !== 4'b0000 || buf_full[0] !== 1'b1) begin
      bad++; $display("FAIL wrap_err_pulse got perr=%b full0=%b want 0000/1", push_err, buf_full[0]);
    end
    selector     = 2'd0;
    selector_enb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      total++;
      if (valid_out !== 1'b1 || data_out !== 8'(8'h40 + k)) begin
        bad++; $display("FAIL wrap_drain k=%0d got valid=%b data=%h want 1/%h", k, valid_out, data_out, 8'(8'h40 + k));
      end
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      push_one(0, 8'(8'hA0 + k));
      selector     = 2'd0;
      selector_enb = 1'b1;
      step();
      selector_enb = 1'b0;
      total++;
      if (valid_out !== 1'b1 || data_out !== 8'(8'hA0 + k)) begin
        bad++; $display("FAIL wrap_second k=%0d got valid=%b data=%h want 1/%h", k, valid_out, data_out, 8'(8'hA0 + k));
      end
    end
    total++;
    if (buf_empty !== 4'b1111) begin
      bad++; $display("FAIL wrap_end_empty got=%b want=1111", buf_empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 8; k++) push_one(1, 8'(8'h10 + k));
    push              = 4'b0010;
    data_in[15:8]     = 8'hFF;
    selector          = 2'd1;
    selector_enb      = 1'b1;
    step();
    idle();
    total++;
    if (push_err !== 4'b0010 || valid_out !== 1'b1 || data_out !== 8'h10 || buf_full[1] !== 1'b0) begin
      bad++; $display("FAIL sim_full got perr=%b valid=%b data=%h full1=%b want 0010/1/10/0", push_err, valid_out, data_out, buf_full[1]);
    end
    selector_enb = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
      total++;
      if (valid_out !== 1'b1 || data_out !== 8'(8'h10 + k)) begin
        bad++; $display("FAIL sim_drain k=%0d got valid=%b data=%h want 1/%h", k, valid_out, data_out, 8'(8'h10 + k));
      end
    end
    idle();
    step();
    total++;
    if (buf_empty[1] !== 1'b1) begin
      bad++; $display("FAIL sim_count7 got empty1=%b want 1", buf_empty[1]);
    end
    push          = 4'b1000;
    data_in[31:24] = 8'h5A;
    selector      = 2'd3;
    selector_enb  = 1'b1;
    step();
    idle();
    total++;
    if (pop_err !== 1'b1 || valid_out !== 1'b0 || data_out !== 8'h17 || buf_empty[3] !== 1'b0) begin
      bad++; $display("FAIL sim_empty got poperr=%b valid=%b data=%h empty3=%b want 1/0/17/0", pop_err, valid_out, data_out, buf_empty[3]);
    end
    selector_enb = 1'b1;
    step();
    idle();
    total++;
    if (pop_err !== 1'b0 || valid_out !== 1'b1 || data_out !== 8'h5A) begin
      bad++; $display("FAIL sim_pop3 got poperr=%b valid=%b data=%h want 0/1/5A", pop_err, valid_out, data_out);
    end
    step();
    total++;
    if (buf_empty !== 4'b1111 || valid_out !== 1'b0) begin
      bad++; $display("FAIL sim_count1 got empty=%b valid=%b want 1111/0", buf_empty, valid_out);
    end
  endtask

  task automatic test_enable_gating();
    push_one(0, 8'h77);
    enb          = 1'b0;
    push         = 4'b1111;
    data_in      = 32'hCAFEF00D;
    selector     = 2'd0;
    selector_enb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (valid_out !== 1'b0 || push_err !== 4'b0000 || pop_err !== 1'b0 || buf_empty !== 4'b1110) begin
        bad++; $display("FAIL gate cyc=%0d got valid=%b perr=%b poperr=%b empty=%b want 0/0000/0/1110", c, valid_out, push_err, pop_err, buf_empty);
      end
    end
    enb  = 1'b1;
    push = 4'b0000;
    step();
    idle();
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h77) begin
      bad++; $display("FAIL gate_resume got valid=%b data=%h want 1/77", valid_out, data_out);
    end
    step();
    total++;
    if (buf_empty !== 4'b1111) begin
      bad++; $display("FAIL gate_end_empty got=%b want=1111", buf_empty);
    end
  endtask

  task automatic test_multi_push();
    push         = 4'b1111;
    data_in      = 32'hD4C3B2A1;
    selector_enb = 1'b0;
    step();
    idle();
    total++;
    if (buf_empty !== 4'b0000 || push_err !== 4'b0000) begin
      bad++; $display("FAIL multi_push got empty=%b perr=%b want 0000/0000", buf_empty, push_err);
    end
    selector_enb = 1'b1;
    for (int q = 0; q < 4; q++) begin
      logic [31:0] ref_word;
      ref_word = 32'hD4C3B2A1;
      selector = 2'(q);
      step();
      total++;
      if (valid_out !== 1'b1 || data_out !== ref_word[q*8 +: 8]) begin
        bad++; $display("FAIL multi_pop q=%0d got valid=%b data=%h want 1/%h", q, valid_out, data_out, ref_word[q*8 +: 8]);
      end
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    int weights [4];
    int popped  [4];
    weights = '{1, 2, 3, 2};
    popped  = '{0, 0, 0, 0};
    for (int k = 0; k < 8; k++) begin
      push = 4'b1111;
      for (int q = 0; q < 4; q++) data_in[q*8 +: 8] = 8'(q * 16 + k);
      step();
    end
    push = 4'b0000;
    total++;
    if (buf_full !== 4'b1111) begin
      bad++; $display("FAIL arb_prefill got full=%b want 1111", buf_full);
    end
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < 4; q++) begin
        for (int w = 0; w < weights[q]; w++) begin
          selector     = 2'(q);
          selector_enb = 1'b1;
          step();
          total++;
          if (pop_err !== 1'b0 || valid_out !== 1'b1 || data_out !== 8'(q * 16 + popped[q])) begin
            bad++; $display("FAIL arb_pop q=%0d n=%0d got poperr=%b valid=%b data=%h want 0/1/%h", q, popped[q], pop_err, valid_out, data_out, 8'(q * 16 + popped[q]));
          end
          if (valid_out === 1'b1) popped[q]++;
        end
      end
    end
    idle();
    step();
    for (int q = 0; q < 4; q++) begin
      total++;
      if (popped[q] != 2 * weights[q]) begin
        bad++; $display("FAIL arb_count q=%0d got=%0d want=%0d", q, popped[q], 2 * weights[q]);
      end
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    enb          = 1'b0;
    push         = 4'b0000;
    data_in      = 32'h0;
    selector     = 2'd0;
    selector_enb = 1'b0;
    test_reset();
    test_fifo_order();
    test_full_wrap();
    test_simultaneous();
    test_enable_gating();
    test_multi_push();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
